bambu_slave_mem_initiator: RTL
==============================

Name: bambu_slave_mem_initiator

Overview:
- Bus master for the Bambu-generated accelerator's slave memory port (S_oe_ram / S_we_ram / S_addr_ram / S_Wdata_ram / S_data_ram_size in; Sout_Rdata_ram / Sout_DataRdy out).
- Lets a bench or host-side controller preload inputs and read back results over one selected channel, instead of tying the slave port to 0.
- Accepts single or burst read/write commands through a valid/ready interface and returns one response per beat.
- Enforces a per-beat timeout.

Parameters:
- CHANNELS, 2, number of slave channels packed on the bus.
- CH, 0, channel index this block drives (0..CHANNELS-1).
- ADDR_W, 7, address bits per channel.
- DATA_W, 8, data bits per channel.
- SIZE_W, 4, size-field bits per channel.
- LEN_W, 8, burst length width.
- TIMEOUT, 64, maximum cycles a request waits for DataRdy (≥2).

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  start byte address.
- cmd_wdata  in  DATA_W  write data, repeated on every beat of a write burst.
- cmd_len  in  LEN_W  beats − 1; 0 means one beat.
- rsp_valid  out  1  beat response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_rdata  out  DATA_W  read data; 0 for writes.
- rsp_err  out  1  beat timed out.
- rsp_last  out  1  final response of the command.
- S_oe_ram  out  CHANNELS  read strobe per channel.
- S_we_ram  out  CHANNELS  write strobe per channel.
- S_addr_ram  out  CHANNELS*ADDR_W  packed addresses; channel c occupies bits [c*ADDR_W +: ADDR_W].
- S_Wdata_ram  out  CHANNELS*DATA_W  packed write data.
- S_data_ram_size  out  CHANNELS*SIZE_W  packed access size in bits.
- Sout_Rdata_ram  in  CHANNELS*DATA_W  packed read data.
- Sout_DataRdy  in  CHANNELS  per-channel completion.

Behaviour:
- Reset: state IDLE; all outputs 0, including cmd_ready, rsp_*, and every S_* bit. Reset asserted mid-transaction aborts it with no response, and the bus is 0 on the next cycle.
- Only channel CH's slices are ever nonzero. S_data_ram_size[CH] is DATA_W whenever a strobe is high, else 0.
- IDLE: cmd_ready = 1. On handshake, latch write, addr, wdata, and remaining = cmd_len; clear the timeout counter; go to REQ.
- REQ: drive S_oe_ram[CH] = ~write, S_we_ram[CH] = write, addr slice, and wdata slice (write only). Signals are held stable until completion or timeout.
  - If Sout_DataRdy[CH] = 1: capture the Rdata slice (reads) into rsp_rdata, set rsp_err = 0, drop the strobes next cycle, go to RESP.
  - Else if counter = TIMEOUT−1: drop the strobes, set rsp_err = 1, rsp_rdata = 0, force remaining = 0, go to RESP.
  - Else increment the counter.
  - DataRdy arriving in the same cycle the counter hits TIMEOUT−1 counts as success.
- RESP: rsp_valid = 1; rsp_last = (remaining == 0). rsp_* stay stable until rsp_ready.
  - On rsp_ready: if remaining == 0, go to IDLE. Otherwise addr ← addr + DATA_W/8 (modulo 2^ADDR_W, wraps to 0), remaining − 1, clear the counter, go to REQ.
- Latency: at least one cycle between beats with strobes low (REQ→RESP→REQ). Minimum command-to-first-response is 3 cycles with DataRdy in the first REQ cycle.
- Sout_DataRdy seen outside REQ, or on other channels, is ignored.
- cmd_ready is 0 in REQ and RESP; there is no command queueing.

Test Plan:
- Single write, CH=0: cmd addr=0x10, wdata=0xA5, len=0; slave DataRdy[0] in the 2nd REQ cycle -> we[0]=1 with addr[6:0]=0x10 and Wdata[7:0]=0xA5 for exactly 2 cycles; size[3:0]=8; rsp_valid with err=0, last=1, rdata=0; channel 1 slices stay 0 throughout.
- Read burst: addr=0x7E, len=3, slave returns 0x11/0x22/0x33/0x44 -> addresses 0x7E, 0x7F, 0x00, 0x01 (wrap); four responses with those data values; last=1 only on the 4th; a strobe-low gap between beats.
- Backpressure: hold rsp_ready=0 for 5 cycles on beat 1 of a len=1 read -> rsp_rdata stable, no 2nd request issued until the handshake.
- Timeout: TIMEOUT=8, read with no DataRdy -> oe held 8 cycles, then rsp_err=1, rdata=0, last=1; with len=2, no further beats.
- Boundary: DataRdy asserted exactly on cycle 8 with TIMEOUT=8 -> success, err=0. DataRdy pulsed in IDLE -> no effect.
- Reset mid-burst (beat 2 of len=3) -> next cycle all outputs 0, state IDLE; a new command is accepted on the following cycle.

Source files
------------

// File: rtl/bambu_slave_mem_initiator.sv
// Bus master for the Bambu accelerator slave memory port: issues single or burst
// read/write beats on one channel and returns one response per beat, with a per-beat timeout.
module bambu_slave_mem_initiator #(
    parameter int CHANNELS = 2,
    parameter int CH       = 0,
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 8,
    parameter int SIZE_W   = 4,
    parameter int LEN_W    = 8,
    parameter int TIMEOUT  = 64
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic                         cmd_write,
    input  logic [ADDR_W-1:0]            cmd_addr,
    input  logic [DATA_W-1:0]            cmd_wdata,
    input  logic [LEN_W-1:0]             cmd_len,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [DATA_W-1:0]            rsp_rdata,
    output logic                         rsp_err,
    output logic                         rsp_last,
    output logic [CHANNELS-1:0]          S_oe_ram,
    output logic [CHANNELS-1:0]          S_we_ram,
    output logic [CHANNELS*ADDR_W-1:0]   S_addr_ram,
    output logic [CHANNELS*DATA_W-1:0]   S_Wdata_ram,
    output logic [CHANNELS*SIZE_W-1:0]   S_data_ram_size,
    input  logic [CHANNELS*DATA_W-1:0]   Sout_Rdata_ram,
    input  logic [CHANNELS-1:0]          Sout_DataRdy
);

    localparam int CNT_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } state_t;

    state_t              state, state_n;
    logic                armed;
    logic                wr_q, wr_n;
    logic [ADDR_W-1:0]   addr_q, addr_n;
    logic [DATA_W-1:0]   wdata_q, wdata_n;
    logic [LEN_W-1:0]    remaining, remaining_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic [DATA_W-1:0]   rdata_q, rdata_n;
    logic                err_q, err_n;

    // Only channel CH is observed; the rest of the bus is folded here so every bit has a reader.
    logic unused_inputs;
    assign unused_inputs = ^{Sout_Rdata_ram, Sout_DataRdy};

    // armed holds cmd_ready low for the first cycle after reset so the whole port reads 0.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            armed     <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            remaining <= '0;
            cnt       <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_n;
            armed     <= 1'b1;
            wr_q      <= wr_n;
            addr_q    <= addr_n;
            wdata_q   <= wdata_n;
            remaining <= remaining_n;
            cnt       <= cnt_n;
            rdata_q   <= rdata_n;
            err_q     <= err_n;
        end
    end

    always_comb begin
        state_n         = state;
        wr_n            = wr_q;
        addr_n          = addr_q;
        wdata_n         = wdata_q;
        remaining_n     = remaining;
        cnt_n           = cnt;
        rdata_n         = rdata_q;
        err_n           = err_q;
        cmd_ready       = 1'b0;
        rsp_valid       = 1'b0;
        rsp_rdata       = '0;
        rsp_err         = 1'b0;
        rsp_last        = 1'b0;
        S_oe_ram        = '0;
        S_we_ram        = '0;
        S_addr_ram      = '0;
        S_Wdata_ram     = '0;
        S_data_ram_size = '0;

        case (state)
            IDLE: begin
                cmd_ready = armed;
                if (cmd_valid && armed) begin
                    wr_n        = cmd_write;
                    addr_n      = cmd_addr;
                    wdata_n     = cmd_wdata;
                    remaining_n = cmd_len;
                    cnt_n       = '0;
                    state_n     = REQ;
                end
            end

            REQ: begin
                S_oe_ram[CH]                          = ~wr_q;
                S_we_ram[CH]                          = wr_q;
                S_addr_ram[CH*ADDR_W +: ADDR_W]       = addr_q;
                S_data_ram_size[CH*SIZE_W +: SIZE_W]  = SIZE_W'(DATA_W);
                if (wr_q) begin
                    S_Wdata_ram[CH*DATA_W +: DATA_W] = wdata_q;
                end
                // A completion on the last allowed cycle still wins over the timeout.
                if (Sout_DataRdy[CH]) begin
                    rdata_n = wr_q ? '0 : Sout_Rdata_ram[CH*DATA_W +: DATA_W];
                    err_n   = 1'b0;
                    state_n = RESP;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    rdata_n     = '0;
                    err_n       = 1'b1;
                    remaining_n = '0;
                    state_n     = RESP;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end

            RESP: begin
                rsp_valid = 1'b1;
                rsp_rdata = rdata_q;
                rsp_err   = err_q;
                rsp_last  = (remaining == '0);
                if (rsp_ready) begin
                    if (remaining == '0) begin
                        state_n = IDLE;
                    end else begin
                        addr_n      = addr_q + ADDR_W'(DATA_W / 8);
                        remaining_n = remaining - LEN_W'(1);
                        cnt_n       = '0;
                        state_n     = REQ;
                    end
                end
            end

            default: state_n = IDLE;
        endcase
    end

endmodule
